// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instructions from a valid/ready stream and writes
// the packed words to instruction memory at consecutive word addresses.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            mnem,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [15:0]           imm,
  input  logic [25:0]           target,
  input  logic                  last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH+1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_full,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_last;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic                  r_err_ill;
  logic                  r_err_full;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_legal;
  logic [31:0]           w_word;
  logic                  w_ptr_max;

  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    unique case (mnem)
      4'd0:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd3:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd4:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd5:    w_word = {6'h23, rs, rt, imm};
      4'd6:    w_word = {6'h2B, rs, rt, imm};
      4'd7:    w_word = {6'h04, rs, rt, imm};
      4'd8:    w_word = {6'h08, rs, rt, imm};
      4'd9:    w_word = {6'h02, target};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_ptr_max = (r_ptr == '1);

  // The write address is captured at the handshake: the pointer cannot move
  // before the following WRITE cycle, and the outputs then hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_last     <= 1'b0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_err_ill  <= 1'b0;
      r_err_full <= 1'b0;
      r_count    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_ACCEPT;
            r_ptr      <= '0;
            r_count    <= '0;
            r_err_ill  <= 1'b0;
            r_err_full <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            if (w_legal) begin
              r_wdata <= w_word;
              r_addr  <= {r_ptr, 2'b00};
              r_last  <= last;
              r_state <= S_WRITE;
            end else begin
              r_err_ill <= 1'b1;
              if (last) r_state <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          r_count <= r_count + 1'b1;
          if (r_last) begin
            r_state <= S_DONE;
          end else if (w_ptr_max) begin
            r_err_full <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_ptr   <= r_ptr + 1'b1;
            r_state <= S_ACCEPT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_ACCEPT);
  assign imem_we     = (r_state == S_WRITE);
  assign busy        = (r_state == S_ACCEPT) || (r_state == S_WRITE);
  assign done        = (r_state == S_DONE);
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign err_illegal = r_err_ill;
  assign err_full    = r_err_full;
  assign count       = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, last;
  logic [3:0]    mnem;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          in_ready, imem_we, busy, done, err_illegal, err_full;
  logic [AW+1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target), .last(last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .err_illegal(err_illegal), .err_full(err_full),
    .count(count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: {legal, word}
  function automatic logic [32:0] ref_enc(input logic [3:0] mn, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] c,
                                          input logic [15:0] im, input logic [25:0] tg);
    logic [5:0] funct_tab [0:4];
    logic [5:0] op_tab [0:3];
    int idx;
    funct_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    op_tab    = '{6'h23, 6'h2B, 6'h04, 6'h08};
    idx = int'(mn);
    if (idx <= 4) return {1'b1, 6'h00, a, b, c, 5'd0, funct_tab[idx]};
    if (idx <= 8) return {1'b1, op_tab[idx-5], a, b, im};
    if (idx == 9) return {1'b1, 6'h02, tg};
    return 33'd0;
  endfunction

  // Behavioural model: session open/closed, one pending word, counters.
  bit          m_active, m_pending, m_plast, m_done, m_eill, m_efull;
  int          m_ptr, m_count, m_addr;
  logic [31:0] m_data;

  always @(posedge clk) begin : model
    logic [32:0] e;
    if (reset) begin
      m_active = 0; m_pending = 0; m_plast = 0; m_done = 0;
      m_eill = 0; m_efull = 0; m_ptr = 0; m_count = 0; m_addr = 0; m_data = '0;
    end else if (m_pending) begin
      m_pending = 0;
      m_count++;
      if (m_plast) begin
        m_active = 0; m_done = 1;
      end else if (m_ptr == DEPTH - 1) begin
        m_efull = 1; m_active = 0; m_done = 1;
      end else begin
        m_ptr++;
      end
    end else if (m_active) begin
      if (in_valid) begin
        e = ref_enc(mnem, rs, rt, rd, imm, target);
        if (e[32]) begin
          m_pending = 1; m_plast = last; m_addr = m_ptr * 4; m_data = e[31:0];
        end else begin
          m_eill = 1;
          if (last) begin
            m_active = 0; m_done = 1;
          end
        end
      end
    end else if (start) begin
      m_active = 1; m_done = 0; m_ptr = 0; m_count = 0; m_eill = 0; m_efull = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",    in_ready,    64'(m_active && !m_pending));
      check("imem_we",     imem_we,     64'(m_pending));
      check("busy",        busy,        64'(m_active));
      check("done",        done,        64'(m_done));
      check("err_illegal", err_illegal, 64'(m_eill));
      check("err_full",    err_full,    64'(m_efull));
      check("count",       count,       64'(m_count));
      check("imem_addr",   imem_addr,   64'(m_addr));
      check("imem_wdata",  imem_wdata,  64'(m_data));
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    to_drive();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] mn, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [15:0] im, input logic [25:0] tg,
                      input logic lst, output bit acc);
    mnem = mn; rs = a; rt = b; rd = c; imm = im; target = tg; last = lst;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc = 1'b1;
      to_drive();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    int nacc;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    mnem = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
    to_drive();
    to_drive();
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    to_drive();

    // single add
    do_start();
    send(4'd0, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0, 1'b1, acc);
    check("add_acc", 64'(acc), 1);
    @(negedge clk);
    check("add_we", imem_we, 1);
    check("add_addr", imem_addr, 0);
    check("add_data", imem_wdata, 64'h01095020);
    to_drive();
    @(negedge clk);
    check("add_done", done, 1);
    check("add_count", count, 1);
    to_drive();

    // lw / beq / j stream
    do_start();
    send(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, acc);
    @(negedge clk);
    check("lw_data", imem_wdata, 64'h8FA80004);
    check("lw_ready_low", in_ready, 0);
    to_drive();
    send(4'd7, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0, 1'b0, acc);
    @(negedge clk);
    check("beq_addr", imem_addr, 4);
    check("beq_data", imem_wdata, 64'h1109FFFF);
    to_drive();
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, acc);
    @(negedge clk);
    check("j_addr", imem_addr, 8);
    check("j_data", imem_wdata, 64'h08000010);
    to_drive();
    @(negedge clk);
    check("stream_count", count, 3);
    to_drive();

    // illegal between two legal
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, acc);
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, acc);
    @(negedge clk);
    check("ill_no_we", imem_we, 0);
    check("ill_flag", err_illegal, 1);
    to_drive();
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, acc);
    @(negedge clk);
    check("ill_next_addr", imem_addr, 4);
    to_drive();
    @(negedge clk);
    check("ill_count", count, 2);
    to_drive();

    // fill memory without last
    do_start();
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      send(4'd2, 5'(k), 5'd1, 5'd2, 16'h0, 26'h0, 1'b0, acc);
      if (acc) nacc++;
    end
    check("full_accepted", 64'(nacc), 4);
    @(negedge clk);
    check("full_done", done, 1);
    check("full_err", err_full, 1);
    check("full_count", count, 4);
    to_drive();

    // start while busy ignored, start in DONE clears
    do_start();
    send(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, acc);
    send(4'd3, 5'd7, 5'd7, 5'd7, 16'h0, 26'h0, 1'b0, acc);
    start = 1'b1;
    to_drive();
    start = 1'b1;
    to_drive();
    start = 1'b0;
    send(4'd4, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b1, acc);
    @(negedge clk);
    check("busy_start_addr", imem_addr, 4);
    to_drive();
    do_start();
    @(negedge clk);
    check("restart_done", done, 0);
    check("restart_count", count, 0);
    check("restart_ill", err_illegal, 0);
    to_drive();
    send(4'd8, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0, 1'b1, acc);
    @(negedge clk);
    check("restart_addr", imem_addr, 0);
    check("addi_data", imem_wdata, 64'h20431234);
    to_drive();

    // reset during WRITE
    do_start();
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h8, 26'h0, 1'b0, acc);
    reset = 1'b1;
    to_drive();
    reset = 1'b0;
    @(negedge clk);
    check("rstw_we", imem_we, 0);
    check("rstw_addr", imem_addr, 0);
    check("rstw_data", imem_wdata, 0);
    to_drive();
    do_start();
    send(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b1, acc);
    @(negedge clk);
    check("rstw_new_addr", imem_addr, 0);
    to_drive();

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset    = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      mnem     = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rs       = 5'($urandom);
      rt       = 5'($urandom);
      rd       = 5'($urandom);
      imm      = 16'($urandom);
      target   = 26'($urandom);
      last     = ($urandom_range(0, 5) == 0);
      to_drive();
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    to_drive();
    to_drive();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the single-cycle MIPS core. It accepts symbolic instructions over a valid/ready stream, one mnemonic code plus operand fields at a time. Each instruction is packed into the 32-bit MIPS word that the core's decoder consumes, and the word is written into instruction memory at consecutive word-aligned addresses. It is the producer side of the opcode/funct encoding that the core's control decode interprets. It sits between the testbench or boot host and the instruction-memory write port.

## Interface
- ADDR_WIDTH, 6, word-index width; memory depth DEPTH = 2^ADDR_WIDTH words
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load session; honoured only in IDLE or DONE
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept an instruction this cycle
- mnem  in  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 addi, 9 j; 10–15 illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate for I-type
- target  in  26  jump target field
- last  in  1  marks the final instruction of the session
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH+2  byte address = {word_ptr, 2'b00}
- imem_wdata  out  32  encoded instruction
- busy  out  1  session in progress (ACCEPT or WRITE)
- done  out  1  session finished; held until next start/reset
- err_illegal  out  1  sticky: an illegal mnem was accepted this session
- err_full  out  1  sticky: session ended because memory filled without last
- count  out  ADDR_WIDTH+1  words written this session

## Operation
- Encoding:
  - R-type (mnem 0–4): {6'h00, rs, rt, rd, 5'b0, funct}, with funct 0x20/0x22/0x24/0x25/0x2A.
  - I-type: {op, rs, rt, imm}, with op lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
  - j: {6'h02, target}.
  - Unused fields are ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: start → ACCEPT. On that transition, word_ptr, count, done, err_illegal and err_full all clear to 0.
  - ACCEPT: in_ready=1. Handshake (in_valid & in_ready):
    - Legal mnem: latch the encoded word and last, then → WRITE.
    - Illegal mnem: set err_illegal, write nothing, pointer unchanged. If last, → DONE; else stay in ACCEPT.
  - WRITE: imem_we=1 for exactly one cycle, imem_addr={word_ptr,2'b00}, imem_wdata=latched word. At the end of the cycle, word_ptr and count increment.
    - If latched last, → DONE.
    - Else if word_ptr was DEPTH−1, set err_full and → DONE.
    - Else → ACCEPT.
  - DONE: done=1. start → ACCEPT with a fresh session (same clears as IDLE).
- start is ignored in ACCEPT and WRITE.
- No wrap-around: the pointer never passes DEPTH−1 within a session. count reaches DEPTH at most.
- Reset values (also when reset is asserted mid-session):
  - State IDLE.
  - in_ready, imem_we, busy, done, err_illegal, err_full = 0.
  - count, imem_addr, imem_wdata = 0.
  - A write pending in WRITE is dropped.

## Timing
- Throughput: one instruction per 2 cycles (ACCEPT, WRITE). in_ready is low during WRITE.
- Latency: handshake at edge N → imem_we high during cycle N+1, with the write taking effect at edge N+1.
- busy = (state==ACCEPT)|(state==WRITE), decoded from registered state.
- imem_addr and imem_wdata hold their last values outside WRITE. Only imem_we qualifies them.
- in_valid may stay high across WRITE. Only the ACCEPT-cycle handshake is sampled.
- done asserts the cycle after the final WRITE, or the cycle after an illegal instruction that carried last.

## Test plan
- Reset, then start; send add rs=8 rt=9 rd=10 with last=1 → one write, imem_addr=0, imem_wdata=0x01095020; then done=1, count=1.
- Stream lw rs=29 rt=8 imm=4; beq rs=8 rt=9 imm=0xFFFF; j target=0x10 (last) → writes 0x8FA80004 @0, 0x1109FFFF @4, 0x08000010 @8 on alternating cycles; in_ready toggles 1/0.
- mnem=12 between two legal instructions → err_illegal=1, no imem_we for it; second legal instruction lands at addr 4; count=2.
- ADDR_WIDTH=2, send 5 instructions with last=0 → 4 writes at addr 0,4,8,12; then done=1, err_full=1, count=4; in_ready=0 and the fifth instruction is never accepted.
- Assert reset in the WRITE cycle → imem_we=0 on the following cycle, all outputs at reset values; a new start writes from addr 0.
- Pulse start while busy → ignored, session unaffected. Pulse start in DONE → errors, done and count cleared; the next write goes to addr 0.
